// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/MRET sequencer: owns the CSR file write/read ports, sequences mepc/mcause/mstatus updates, then redirects.
// Optional macro CSR_TRAP_VECTORED_EN: vectored interrupt dispatch when mtvec[1:0] == 2'b01.
module csr_trap_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] trap_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mret_valid,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic        cpu_csr_we,
  input  logic [11:0] cpu_csr_waddr,
  input  logic [31:0] cpu_csr_wdata,
  input  logic [11:0] cpu_csr_raddr,
  output logic [31:0] cpu_csr_rdata,
  output logic        w_enable,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_val,
  output logic [11:0] csr_r_addr,
  input  logic [31:0] csr_r_val,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] T_EPC   = 3'd1;
  localparam logic [2:0] T_CAUSE = 3'd2;
  localparam logic [2:0] T_STAT  = 3'd3;
  localparam logic [2:0] M_STAT  = 3'd4;
  localparam logic [2:0] REDIR   = 3'd5;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [2:0]  state;
  logic [31:2] lat_pc;
  logic [31:0] lat_cause;
  logic [31:0] lat_mstatus;
  logic [31:0] lat_target;   // mtvec on the trap path, mepc on the MRET path
  logic        lat_mret;

  logic [2:0]  pend;
  logic        irq_take, trap_go, is_idle, accept;
  logic [31:0] next_cause, trap_mstatus, mret_mstatus, vec_pc, base;
  logic        unused_bits;

  assign unused_bits = ^{mie_in[31:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};

  assign pend     = {irq_ext & mie_in[11], irq_sw & mie_in[3], irq_timer & mie_in[7]};
  assign irq_take = mstatus_in[3] & (|pend);
  assign trap_go  = exc_valid | irq_take;
  assign is_idle  = (state == IDLE);
  assign accept   = is_idle & ~reset & (trap_go | mret_valid);
  assign stall    = ~is_idle | accept;
  assign cpu_csr_rdata = csr_r_val;

  always_comb begin
    next_cause = 32'h0;
    if (exc_valid)    next_cause = {1'b0, exc_cause};
    else if (pend[2]) next_cause = 32'h8000_000B;
    else if (pend[1]) next_cause = 32'h8000_0003;
    else if (pend[0]) next_cause = 32'h8000_0007;
  end

  always_comb begin
    trap_mstatus        = lat_mstatus;
    trap_mstatus[12:11] = 2'b11;
    trap_mstatus[7]     = lat_mstatus[3];
    trap_mstatus[3]     = 1'b0;
    mret_mstatus        = lat_mstatus;
    mret_mstatus[12:11] = 2'b11;
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[3]     = lat_mstatus[7];
  end

  assign base = {lat_target[31:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
  // Code is scaled by 4 in 32-bit arithmetic, so large codes wrap.
  assign vec_pc = (lat_target[1:0] == 2'b01 && lat_cause[31]) ?
                  base + {lat_cause[29:0], 2'b00} : base;
`else
  assign vec_pc = base;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_pc      <= '0;
      lat_cause   <= '0;
      lat_mstatus <= '0;
      lat_target  <= '0;
      lat_mret    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_pc      <= trap_pc[31:2];
          lat_cause   <= next_cause;
          lat_mstatus <= mstatus_in;
          lat_mret    <= ~trap_go;
          state       <= trap_go ? T_EPC : M_STAT;
        end
        T_EPC: begin
          lat_target <= csr_r_val;
          state      <= T_CAUSE;
        end
        T_CAUSE: state <= T_STAT;
        T_STAT:  state <= REDIR;
        M_STAT: begin
          lat_target <= csr_r_val;
          state      <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_enable       = 1'b0;
    csr_w_addr     = 12'h0;
    csr_w_val      = 32'h0;
    csr_r_addr     = 12'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      IDLE: begin
        csr_r_addr = cpu_csr_raddr;
        if (!accept && !reset && cpu_csr_we) begin
          w_enable   = 1'b1;
          csr_w_addr = cpu_csr_waddr;
          csr_w_val  = cpu_csr_wdata;
        end
      end
      T_EPC: begin
        w_enable   = 1'b1;
        csr_w_addr = A_MEPC;
        csr_w_val  = {lat_pc, 2'b00};
        csr_r_addr = A_MTVEC;
      end
      T_CAUSE: begin
        w_enable   = 1'b1;
        csr_w_addr = A_MCAUSE;
        csr_w_val  = lat_cause;
      end
      T_STAT: begin
        w_enable   = 1'b1;
        csr_w_addr = A_MSTATUS;
        csr_w_val  = trap_mstatus;
      end
      M_STAT: begin
        w_enable   = 1'b1;
        csr_w_addr = A_MSTATUS;
        csr_w_val  = mret_mstatus;
        csr_r_addr = A_MEPC;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = lat_mret ? lat_target : vec_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: directed scenarios plus random traffic against a CSR-level model.
module tb_csr_trap_ctrl;
  logic        clock = 1'b0, reset = 1'b1;
  logic        exc_valid = 0, irq_ext = 0, irq_sw = 0, irq_timer = 0, mret_valid = 0, cpu_csr_we = 0;
  logic [30:0] exc_cause = '0;
  logic [31:0] trap_pc = '0, mstatus_in, mie_in, cpu_csr_wdata = '0, csr_r_val;
  logic [11:0] cpu_csr_waddr = '0, cpu_csr_raddr = '0;
  logic [31:0] cpu_csr_rdata, csr_w_val, redirect_pc;
  logic [11:0] csr_w_addr, csr_r_addr;
  logic        w_enable, stall, redirect_valid;

  csr_trap_ctrl dut (
    .clock(clock), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause), .trap_pc(trap_pc),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer), .mret_valid(mret_valid),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .cpu_csr_we(cpu_csr_we), .cpu_csr_waddr(cpu_csr_waddr),
    .cpu_csr_wdata(cpu_csr_wdata), .cpu_csr_raddr(cpu_csr_raddr), .cpu_csr_rdata(cpu_csr_rdata),
    .w_enable(w_enable), .csr_w_addr(csr_w_addr), .csr_w_val(csr_w_val), .csr_r_addr(csr_r_addr),
    .csr_r_val(csr_r_val), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  // Register file environment the DUT writes into.
  logic [31:0] rf [0:4095];
  always @(posedge clock) if (w_enable) rf[csr_w_addr] <= csr_w_val;
  assign csr_r_val  = rf[csr_r_addr];
  assign mstatus_in = rf[12'h300];
  assign mie_in     = rf[12'h304];

  typedef struct { int cyc; bit redir; logic [11:0] addr; logic [31:0] data; } ev_t;
  ev_t exp_q[$];
  ev_t pend_q[$];
  logic [31:0] m [0:4095];
  int total = 0, bad = 0, cyc = 0, idle_at = 0;
  bit rd_pass = 0, done = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input bit r, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.redir = r; e.addr = a; e.data = d;
    exp_q.push_back(e);
    pend_q.push_back(e);
  endtask

  // CSR-level reference: decides what the current cycle's inputs cause and schedules the visible effects.
  task automatic model();
    int c = cyc;
    logic [31:0] ms, ie, cause, tgt, nst;
    bit ext, sw, tm, irq;
    ev_t e;
    while (pend_q.size() > 0 && pend_q[0].cyc < c) begin
      e = pend_q.pop_front();
      if (!e.redir) m[e.addr] = e.data;
    end
    rd_pass = 0;
    if (reset) begin
      pend_q.delete(); exp_q.delete(); idle_at = c;
      return;
    end
    if (c < idle_at) return;
    ms = m[12'h300]; ie = m[12'h304];
    ext = irq_ext & ie[11]; sw = irq_sw & ie[3]; tm = irq_timer & ie[7];
    irq = ms[3] & (ext | sw | tm);
    if (exc_valid || irq) begin
      cause = exc_valid ? {1'b0, exc_cause} : ext ? 32'h8000000B : sw ? 32'h80000003 : 32'h80000007;
      push(c + 1, 0, 12'h341, trap_pc & 32'hFFFF_FFFC);
      push(c + 2, 0, 12'h342, cause);
      nst = (ms & ~32'h88) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
      push(c + 3, 0, 12'h300, nst);
      tgt = m[12'h305] & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
      if (m[12'h305][1:0] == 2'b01 && cause[31]) tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
`endif
      push(c + 4, 1, 12'h0, tgt);
      idle_at = c + 5;
    end else if (mret_valid) begin
      nst = (ms & ~32'h88) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
      push(c + 1, 0, 12'h300, nst);
      push(c + 2, 1, 12'h0, m[12'h341]);
      idle_at = c + 3;
    end else begin
      rd_pass = 1;
      if (cpu_csr_we) push(c, 0, cpu_csr_waddr, cpu_csr_wdata);
    end
  endtask

  // Monitor: compares DUT outputs each cycle against the scheduled expectations.
  always @(negedge clock) if (!done) begin
    bit exp_we, exp_rv;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missed_event: got none expected addr %h data %h at cycle %0d", exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    exp_we = exp_q.size() > 0 && exp_q[0].cyc == cyc && !exp_q[0].redir;
    exp_rv = exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].redir;
    chk("stall", {31'b0, stall}, {31'b0, !reset && cyc < idle_at});
    chk("w_enable", {31'b0, w_enable}, {31'b0, exp_we});
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, exp_rv});
    if (w_enable && exp_we) begin
      chk("w_addr", {20'b0, csr_w_addr}, {20'b0, exp_q[0].addr});
      chk("w_val", csr_w_val, exp_q[0].data);
      void'(exp_q.pop_front());
    end else if (redirect_valid && exp_rv) begin
      chk("redirect_pc", redirect_pc, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    if (!w_enable) begin
      chk("w_addr_quiet", {20'b0, csr_w_addr}, 32'h0);
      chk("w_val_quiet", csr_w_val, 32'h0);
    end
    if (reset) chk("redirect_pc_rst", redirect_pc, 32'h0);
    chk("cpu_rdata", cpu_csr_rdata, csr_r_val);
    if (rd_pass) chk("r_addr_pass", {20'b0, csr_r_addr}, {20'b0, cpu_csr_raddr});
  end

  function automatic logic [11:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 12'h300;
      1: return 12'h304;
      2: return 12'h305;
      3: return 12'h341;
      4: return 12'h342;
      default: return r[11:0];
    endcase
  endfunction

  task automatic step(input bit rst, input bit exc, input logic [30:0] cause, input logic [31:0] pc,
                      input logic [2:0] irq, input bit mret, input bit we, input logic [11:0] wa,
                      input logic [31:0] wd);
    @(posedge clock); #1;
    reset = rst; exc_valid = exc; exc_cause = cause; trap_pc = pc;
    {irq_ext, irq_sw, irq_timer} = irq; mret_valid = mret;
    cpu_csr_we = we; cpu_csr_waddr = wa; cpu_csr_wdata = wd; cpu_csr_raddr = pick();
    model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 31'h0, 32'h0, 3'b000, 0, 0, 12'h0, 32'h0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(0, 0, 31'h0, 32'h0, 3'b000, 0, 1, a, d);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin rf[i] = 32'h0; m[i] = 32'h0; end
    repeat (3) step(1, 0, 31'h0, 32'h0, 3'b000, 0, 0, 12'h0, 32'h0);
    idle(2);
    // Exception; concurrent mtvec write and writes during the sequence are dropped.
    wr(12'h305, 32'h100);
    wr(12'h300, 32'h8);
    step(0, 1, 31'h2, 32'h40, 3'b000, 0, 1, 12'h305, 32'hDEAD_BEEF);
    step(0, 1, 31'h9, 32'h44, 3'b111, 1, 0, 12'h0, 32'h0);
    step(0, 0, 31'h0, 32'h0, 3'b000, 0, 1, 12'h342, 32'h1234_5678);
    idle(2);
    wr(12'h342, 32'hA5A5_0001);
    // Interrupt priority, then the same lines with MIE cleared by the trap.
    wr(12'h304, 32'h880);
    wr(12'h300, 32'h8);
    step(0, 0, 31'h0, 32'h0, 3'b101, 0, 0, 12'h0, 32'h0);
    repeat (4) step(0, 0, 31'h0, 32'h0, 3'b101, 0, 0, 12'h0, 32'h0);
    step(0, 0, 31'h0, 32'h0, 3'b101, 0, 1, 12'h342, 32'h1234);
    // Timer interrupt with mtvec in vectored mode.
    wr(12'h305, 32'h201);
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    step(0, 0, 31'h0, 32'h0, 3'b001, 0, 0, 12'h0, 32'h0);
    idle(5);
    // MRET.
    wr(12'h341, 32'h80);
    wr(12'h300, 32'h1880);
    step(0, 0, 31'h0, 32'h0, 3'b000, 1, 0, 12'h0, 32'h0);
    idle(3);
    // Reset two cycles into a trap.
    wr(12'h300, 32'h8);
    step(0, 1, 31'h5, 32'h1000, 3'b000, 0, 0, 12'h0, 32'h0);
    idle(1);
    repeat (2) step(1, 0, 31'h0, 32'h0, 3'b000, 0, 0, 12'h0, 32'h0);
    wr(12'h342, 32'h55);
    idle(2);
    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      logic [31:0] rc, rp, rd;
      logic [2:0] ri;
      rc = $urandom; rp = $urandom; rd = $urandom;
      ri = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
      step(0, $urandom_range(0, 11) == 0, rc[30:0], rp, ri, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, pick(), rd);
    end
    idle(8);
    chk("queue_drained", exp_q.size(), 32'h0);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and MRET sequencer for the machine-mode CSR register file. It owns the register file's single write port and single read port and shares them with the pipeline's CSR-instruction path. On an exception, an enabled interrupt or an MRET, it stalls the pipeline and performs the mepc/mcause/mstatus updates one write per cycle. It then issues a one-cycle PC redirect to the trap vector or to mepc.

## Interface
Parameters:
- None. CSR addresses are fixed: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- exc_valid  in  1  the committing instruction raised an exception.
- exc_cause  in  31  exception code; mcause[31] = 0.
- trap_pc  in  32  faulting PC for an exception; next-to-execute PC for an interrupt.
- irq_ext / irq_sw / irq_timer  in  1 each  level interrupt lines (MEIP / MSIP / MTIP).
- mret_valid  in  1  an MRET is committing.
- mstatus_in  in  32  live mstatus from the register file debug tap.
- mie_in  in  32  live mie from the register file debug tap.
- cpu_csr_we  in  1  pipeline CSR write request.
- cpu_csr_waddr  in  12  pipeline CSR write address.
- cpu_csr_wdata  in  32  pipeline CSR write data.
- cpu_csr_raddr  in  12  pipeline CSR read address.
- cpu_csr_rdata  out  32  equals csr_r_val.
- w_enable  out  1  register file write enable.
- csr_w_addr  out  12  register file write address.
- csr_w_val  out  32  register file write data.
- csr_r_addr  out  12  register file read address.
- csr_r_val  in  32  register file read data (combinational).
- stall  out  1  pipeline must hold.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  redirect target.

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_STAT, M_STAT, REDIR. Reset forces IDLE; any reset mid-sequence aborts it with no further writes.
- Pending interrupts = {irq_ext & mie_in[11], irq_sw & mie_in[3], irq_timer & mie_in[7]}. An interrupt is taken only if mstatus_in[3] (MIE) = 1. Priority among interrupts is ext (code 11) > sw (code 3) > timer (code 7).
- Acceptance happens only in IDLE. Priority is exc_valid > interrupt > mret_valid.
- In the accept cycle:
  - latch trap_pc, the cause (interrupts set bit31 = 1) and mstatus_in;
  - suppress cpu_csr_we;
  - raise stall.
- Trap path: IDLE → T_EPC → T_CAUSE → T_STAT → REDIR → IDLE.
  - T_EPC: write mepc = latched PC (bits [1:0] forced to 0). csr_r_addr = 0x305, and mtvec is latched.
  - T_CAUSE: write mcause = latched cause.
  - T_STAT: write mstatus = latched value with MPIE[7] = old MIE, MIE[3] = 0, MPP[12:11] = 2'b11.
  - REDIR: redirect_pc = {mtvec[31:2], 2'b00}, plus the vector offset (see Configuration).
- MRET path: IDLE → M_STAT → REDIR → IDLE.
  - M_STAT: csr_r_addr = 0x341, and mepc is latched. Write mstatus = latched value with MIE = MPIE, MPIE = 1, MPP = 2'b11.
  - REDIR: redirect_pc = latched mepc.
- In IDLE with no acceptance:
  - w_enable / csr_w_addr / csr_w_val pass cpu_csr_we / cpu_csr_waddr / cpu_csr_wdata through combinationally;
  - csr_r_addr = cpu_csr_raddr.
- In all states other than IDLE:
  - cpu writes are dropped;
  - exc_valid, irq_* and mret_valid are ignored.
- When not writing, w_enable = 0 and csr_w_addr / csr_w_val = 0.

## Timing
- Reset values: state IDLE, stall 0, redirect_valid 0, redirect_pc 0, w_enable 0, all latches 0.
- stall = (state != IDLE) | accept. It is a combinational decode of state and inputs.
- Trap accepted at cycle T:
  - mepc written at T+1, mcause at T+2, mstatus at T+3;
  - redirect_valid at T+4;
  - stall high T..T+4, low at T+5.
- MRET accepted at T:
  - mstatus written at T+1;
  - redirect_valid at T+2;
  - stall high T..T+2.
- redirect_valid is high for exactly one cycle, in REDIR only.
- After a trap, MIE = 0. A still-asserted level interrupt is therefore not re-taken until software re-enables it.
- Back-to-back: a new event may be accepted in the first IDLE cycle after REDIR.

## Configuration
- CSR_TRAP_VECTORED_EN defined:
  - if mtvec[1:0] = 2'b01 and the cause is an interrupt, redirect_pc = base + 4 × code (code = cause[30:0], 32-bit wrap-around arithmetic);
  - exceptions always use base.
- Undefined: mtvec[1:0] is ignored and redirect_pc is always base.

## Test plan
- Reset mid-trap: assert reset at T+2 of a trap → outputs return to reset values immediately; no mstatus write occurs; the FSM is IDLE after release.
- Exception: mstatus_in = 0x8, mtvec = 0x100, exc_cause = 2, trap_pc = 0x40 at T →
  - mepc = 0x40 at T+1;
  - mcause = 0x2 at T+2;
  - mstatus = 0x1880 at T+3;
  - redirect_pc = 0x100 with redirect_valid at T+4.
- Interrupt priority and gating:
  - irq_timer = irq_ext = 1, mie_in = 0x880, MIE = 1 → mcause = 0x8000000B.
  - The same inputs with MIE = 0 → no acceptance; cpu writes pass through.
- Vectored mode: mtvec = 0x201, timer interrupt →
  - with CSR_TRAP_VECTORED_EN, redirect_pc = 0x21C;
  - without it, 0x200.
- MRET: mepc = 0x80, mstatus_in = 0x1880 → mstatus = 0x1888 at T+1; redirect_pc = 0x80 at T+2.
- Arbitration:
  - cpu_csr_we to 0x305 in the same cycle as exc_valid → the write is dropped;
  - cpu_csr_we during T_CAUSE → dropped;
  - cpu_csr_we in IDLE → w_enable is asserted the same cycle with the cpu address and data.
